// File: rtl/alu_cmd_loader_if.sv
// Byte-stream and command-bus signals between the stream source, alu_cmd_loader and the ALU.
// master: the loader (accepts bytes, drives the command); slave: the surrounding source/ALU.
// Valid/ready rule on both channels: a transfer happens at a posedge where valid and ready are both 1;
// the valid side holds its payload stable until that edge and never waits for ready before asserting valid.
interface alu_cmd_loader_if;
    logic [7:0]  In_Data;
    logic        In_Valid;
    logic        In_Ready;
    logic [3:0]  Opcode;
    logic [15:0] Data_A;
    logic [15:0] Data_B;
    logic        Cmd_Valid;
    logic        Cmd_Ready;

    modport master (
        input  In_Data, In_Valid, Cmd_Ready,
        output In_Ready, Opcode, Data_A, Data_B, Cmd_Valid
    );

    modport slave (
        output In_Data, In_Valid, Cmd_Ready,
        input  In_Ready, Opcode, Data_A, Data_B, Cmd_Valid
    );
endinterface

// File: rtl/alu_cmd_loader.sv
// Assembles byte frames {opcode, A_hi, A_lo, B_hi, B_lo} into a registered ALU command.
// Optional CMD_PARITY_EN adds a trailing XOR check byte per frame and the Err_Parity pulse.
module alu_cmd_loader #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Enable,
    alu_cmd_loader_if.master bus,
    output logic             Err_Illegal,
    output logic             Err_Timeout,
`ifdef CMD_PARITY_EN
    output logic             Err_Parity,
`endif
    output logic [CNT_W-1:0] Cmd_Count,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        A_HI   = 3'd1,
        A_LO   = 3'd2,
        B_HI   = 3'd3,
        B_LO   = 3'd4,
        PARITY = 3'd5,
        ISSUE  = 3'd6
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t            state, next_state;
    logic [7:0]        to_cnt;
    logic              ready_en;
    logic              hs, legal, in_frame;
    logic              timeout_hit, illegal_hit, parity_bad;
    logic [3:0]        opcode_q;
    logic [15:0]       data_a_q, data_b_q;
    logic              cmd_valid_q;
    logic [CNT_W-1:0]  cmd_count_q;
    logic              err_illegal_q, err_timeout_q;
`ifdef CMD_PARITY_EN
    logic [7:0]        par_acc;
    logic              err_parity_q;
`endif

    // ready_en keeps In_Ready low through reset and rises the first cycle after release.
    assign bus.In_Ready  = Enable & ready_en & (state != ISSUE);
    assign hs            = bus.In_Valid & bus.In_Ready;
    assign legal         = (bus.In_Data[7:3] == 5'd0);
    assign bus.Opcode    = opcode_q;
    assign bus.Data_A    = data_a_q;
    assign bus.Data_B    = data_b_q;
    assign bus.Cmd_Valid = cmd_valid_q;
    assign Cmd_Count     = cmd_count_q;
    assign Err_Illegal   = err_illegal_q;
    assign Err_Timeout   = err_timeout_q;
    assign dbg_state     = state;
`ifdef CMD_PARITY_EN
    assign Err_Parity    = err_parity_q;
    assign in_frame      = (state == A_HI) || (state == A_LO) || (state == B_HI) ||
                           (state == B_LO) || (state == PARITY);
`else
    assign in_frame      = (state == A_HI) || (state == A_LO) || (state == B_HI) ||
                           (state == B_LO);
`endif

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        timeout_hit = 1'b0;
        illegal_hit = 1'b0;
        parity_bad  = 1'b0;
        case (state)
            IDLE: begin
                if (hs) begin
                    if (!legal) begin
                        illegal_hit = 1'b1;
                    end else if (bus.In_Data[2:0] == 3'd0) begin
`ifdef CMD_PARITY_EN
                        next_state = PARITY;
`else
                        next_state = ISSUE;
`endif
                    end else begin
                        next_state = A_HI;
                    end
                end
            end
            A_HI: if (hs) next_state = A_LO;
            A_LO: if (hs) next_state = B_HI;
            B_HI: if (hs) next_state = B_LO;
            B_LO: begin
                if (hs) begin
`ifdef CMD_PARITY_EN
                    next_state = PARITY;
`else
                    next_state = ISSUE;
`endif
                end
            end
`ifdef CMD_PARITY_EN
            PARITY: begin
                if (hs) begin
                    if (bus.In_Data == par_acc) begin
                        next_state = ISSUE;
                    end else begin
                        parity_bad = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
`endif
            // The command handshake completes even while Enable is low.
            ISSUE: if (cmd_valid_q && bus.Cmd_Ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
        // A byte arriving on the last allowed cycle wins over the timeout.
        if (in_frame && Enable && !hs && (to_cnt == TO_LAST)) begin
            timeout_hit = 1'b1;
            next_state  = IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            to_cnt <= 8'd0;
        end else if (!in_frame || hs || timeout_hit) begin
            to_cnt <= 8'd0;
        end else if (Enable) begin
            to_cnt <= to_cnt + 8'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            ready_en      <= 1'b0;
            opcode_q      <= 4'd0;
            data_a_q      <= 16'd0;
            data_b_q      <= 16'd0;
            cmd_valid_q   <= 1'b0;
            cmd_count_q   <= '0;
            err_illegal_q <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            ready_en      <= 1'b1;
            err_illegal_q <= illegal_hit;
            err_timeout_q <= timeout_hit;
            cmd_valid_q   <= (next_state == ISSUE);
            if (cmd_valid_q && bus.Cmd_Ready) begin
                cmd_count_q <= cmd_count_q + CNT_W'(1);
            end
            if (hs) begin
                case (state)
                    IDLE: if (legal) opcode_q <= bus.In_Data[3:0];
                    A_HI: data_a_q[15:8] <= bus.In_Data;
                    A_LO: data_a_q[7:0]  <= bus.In_Data;
                    B_HI: data_b_q[15:8] <= bus.In_Data;
                    B_LO: data_b_q[7:0]  <= bus.In_Data;
                    default: ;
                endcase
            end
        end
    end

`ifdef CMD_PARITY_EN
    always_ff @(posedge CLK) begin
        if (!RST) begin
            par_acc      <= 8'd0;
            err_parity_q <= 1'b0;
        end else begin
            err_parity_q <= parity_bad;
            if (hs) begin
                par_acc <= (state == IDLE) ? bus.In_Data : (par_acc ^ bus.In_Data);
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_cmd_loader.sv
// Directed bench for alu_cmd_loader: framing, stalls, illegal bytes, timeout, Enable, count wrap, reset.
module tb_alu_cmd_loader;

    logic       CLK;
    logic       RST;
    logic       Enable;
    logic       Err_Illegal;
    logic       Err_Timeout;
`ifdef CMD_PARITY_EN
    logic       Err_Parity;
`endif
    logic [7:0] Cmd_Count;
    logic [2:0] dbg_state;
    int         errors;
    int         checks;

    alu_cmd_loader_if bus ();

    alu_cmd_loader #(.TIMEOUT(16), .CNT_W(8)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .Enable      (Enable),
        .bus         (bus.master),
        .Err_Illegal (Err_Illegal),
        .Err_Timeout (Err_Timeout),
`ifdef CMD_PARITY_EN
        .Err_Parity  (Err_Parity),
`endif
        .Cmd_Count   (Cmd_Count),
        .dbg_state   (dbg_state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.In_Data  = b;
        bus.In_Valid = 1'b1;
        tick();
        bus.In_Valid = 1'b0;
    endtask

    task automatic check_cmd(input string tag, input logic [3:0] op,
                             input logic [15:0] a, input logic [15:0] b);
        chk({tag, "_valid"}, 32'(bus.Cmd_Valid), 32'd1);
        chk({tag, "_op"},    32'(bus.Opcode),    32'(op));
        chk({tag, "_a"},     32'(bus.Data_A),    32'(a));
        chk({tag, "_b"},     32'(bus.Data_B),    32'(b));
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        RST          = 1'b0;
        Enable       = 1'b1;
        bus.In_Data  = 8'h00;
        bus.In_Valid = 1'b0;
        bus.Cmd_Ready = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_in_ready",  32'(bus.In_Ready),  32'd0);
        chk("rst_cmd_valid", 32'(bus.Cmd_Valid), 32'd0);
        chk("rst_opcode",    32'(bus.Opcode),    32'd0);
        chk("rst_data_a",    32'(bus.Data_A),    32'd0);
        chk("rst_data_b",    32'(bus.Data_B),    32'd0);
        chk("rst_count",     32'(Cmd_Count),     32'd0);
        chk("rst_errs",      32'({Err_Illegal, Err_Timeout}), 32'd0);
        chk("rst_state",     32'(dbg_state),     32'd0);
        RST = 1'b1;
        tick();
        chk("post_rst_in_ready", 32'(bus.In_Ready), 32'd1);

        // Back-to-back frame with Cmd_Ready high: 5 byte cycles plus 1 issue cycle
        bus.Cmd_Ready = 1'b1;
        send_byte(8'h01); send_byte(8'h12); send_byte(8'h34); send_byte(8'h00);
        chk("f1_not_yet_valid", 32'(bus.Cmd_Valid), 32'd0);
        send_byte(8'h0F);
        check_cmd("f1", 4'h1, 16'h1234, 16'h000F);
        chk("f1_in_ready_issue", 32'(bus.In_Ready), 32'd0);
        tick();
        chk("f1_valid_drop", 32'(bus.Cmd_Valid), 32'd0);
        chk("f1_count",      32'(Cmd_Count),     32'd1);
        chk("f1_idle",       32'(dbg_state),     32'd0);

        // ALU stalls for 4 cycles: command held, no bytes accepted
        bus.Cmd_Ready = 1'b0;
        send_byte(8'h03); send_byte(8'hAA); send_byte(8'hAA); send_byte(8'h55); send_byte(8'h55);
        check_cmd("f2", 4'h3, 16'hAAAA, 16'h5555);
        bus.In_Data  = 8'h01;
        bus.In_Valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("f2_stall_in_ready", 32'(bus.In_Ready), 32'd0);
            check_cmd("f2_stall", 4'h3, 16'hAAAA, 16'h5555);
        end
        bus.In_Valid  = 1'b0;
        bus.Cmd_Ready = 1'b1;
        tick();
        chk("f2_valid_drop", 32'(bus.Cmd_Valid), 32'd0);
        chk("f2_idle",       32'(dbg_state),     32'd0);
        chk("f2_count",      32'(Cmd_Count),     32'd2);

        // Illegal opcode bytes, then a NOP reusing the held operands
        send_byte(8'h19);
        chk("ill1_pulse", 32'(Err_Illegal), 32'd1);
        chk("ill1_idle",  32'(dbg_state),   32'd0);
        send_byte(8'h08);
        chk("ill2_pulse", 32'(Err_Illegal), 32'd1);
        chk("ill2_no_valid", 32'(bus.Cmd_Valid), 32'd0);
        tick();
        chk("ill_pulse_end", 32'(Err_Illegal), 32'd0);
        send_byte(8'h00);
        check_cmd("nop", 4'h0, 16'hAAAA, 16'h5555);
        tick();
        chk("nop_count", 32'(Cmd_Count), 32'd3);

        // Mid-frame stall of TIMEOUT cycles aborts the frame
        send_byte(8'h02); send_byte(8'hFF);
        chk("to_state_a_lo", 32'(dbg_state), 32'd2);
        repeat (15) tick();
        chk("to_not_yet",   32'(Err_Timeout), 32'd0);
        chk("to_still_alo", 32'(dbg_state),   32'd2);
        tick();
        chk("to_pulse",     32'(Err_Timeout), 32'd1);
        chk("to_idle",      32'(dbg_state),   32'd0);
        chk("to_no_valid",  32'(bus.Cmd_Valid), 32'd0);
        chk("to_partial_a", 32'(bus.Data_A),  32'hFFAA);
        tick();
        chk("to_pulse_end", 32'(Err_Timeout), 32'd0);
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h02);
        check_cmd("after_to", 4'h2, 16'h0001, 16'h0002);
        tick();
        chk("after_to_count", 32'(Cmd_Count), 32'd4);

        // Enable low mid-operand with In_Valid high: nothing taken, no timeout
        send_byte(8'h05); send_byte(8'h12);
        Enable       = 1'b0;
        bus.In_Data  = 8'h34;
        bus.In_Valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("en0_in_ready", 32'(bus.In_Ready), 32'd0);
            chk("en0_state",    32'(dbg_state),    32'd2);
        end
        chk("en0_no_timeout", 32'(Err_Timeout), 32'd0);
        Enable = 1'b1;
        send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        check_cmd("en_resume", 4'h5, 16'h1234, 16'h5678);
        tick();
        chk("en_resume_count", 32'(Cmd_Count), 32'd5);

        // Command handshake completes with Enable low
        bus.Cmd_Ready = 1'b0;
        send_byte(8'h00);
        chk("en0_issue_valid", 32'(bus.Cmd_Valid), 32'd1);
        Enable        = 1'b0;
        bus.Cmd_Ready = 1'b1;
        tick();
        chk("en0_issue_drop",  32'(bus.Cmd_Valid), 32'd0);
        chk("en0_issue_count", 32'(Cmd_Count),     32'd6);
        Enable = 1'b1;

        // Counter wrap: 250 more NOPs bring 6 to 256 == 0
        for (int i = 0; i < 249; i++) begin
            send_byte(8'h00);
            tick();
        end
        chk("count_255", 32'(Cmd_Count), 32'd255);
        send_byte(8'h00);
        tick();
        chk("count_wrap", 32'(Cmd_Count), 32'd0);
        send_byte(8'h00);
        tick();
        chk("count_after_wrap", 32'(Cmd_Count), 32'd1);

        // Reset mid-frame
        send_byte(8'h04); send_byte(8'hAB);
        chk("mid_state", 32'(dbg_state), 32'd2);
        RST = 1'b0;
        tick();
        chk("midrst_state",  32'(dbg_state),     32'd0);
        chk("midrst_valid",  32'(bus.Cmd_Valid), 32'd0);
        chk("midrst_count",  32'(Cmd_Count),     32'd0);
        chk("midrst_data_a", 32'(bus.Data_A),    32'd0);
        chk("midrst_opcode", 32'(bus.Opcode),    32'd0);
        chk("midrst_ready",  32'(bus.In_Ready),  32'd0);

        // Reset mid-issue
        RST = 1'b1;
        tick();
        bus.Cmd_Ready = 1'b0;
        send_byte(8'h00);
        chk("issue_before_rst", 32'(bus.Cmd_Valid), 32'd1);
        RST = 1'b0;
        tick();
        chk("issue_rst_valid", 32'(bus.Cmd_Valid), 32'd0);
        chk("issue_rst_count", 32'(Cmd_Count),     32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
